// File: rtl/prescale_gen.sv
// prescale_gen -- programmable clock-enable generator for the MAC clock domain.
//
// Emits a one-clock `prescaler` strobe every div+1 clocks while enabled. The
// divider can be reloaded at run time; in RUN a new value is held in a shadow
// register and committed only at a period boundary, so the running period is
// never shortened or stretched.
//
// Optional feature macro: PRESCALE_RESYNC_EN
//   When defined, the `resync` input exists and restarts the current period.
//   When undefined, the port is absent and behaviour equals resync tied low.
//
// Parameters:
//   WIDTH      width of divider value and counter
//   RESET_DIV  divider value loaded by reset
//
// Ports:
//   clock        single clock, rising edge
//   reset        synchronous, active-high reset
//   enable       high = run the divider, low = idle
//   brp          new divider value, sampled when brp_load is high
//   brp_load     one-cycle load strobe for brp
//   resync       hard period restart (PRESCALE_RESYNC_EN only)
//   prescaler    registered enable strobe, one clock wide per period
//   busy         high while in RUN
//   brp_pending  high while a loaded value waits for the next period boundary

module prescale_gen #(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned RESET_DIV = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] brp,
    input  logic             brp_load,
`ifdef PRESCALE_RESYNC_EN
    input  logic             resync,
`endif
    output logic             prescaler,
    output logic             busy,
    output logic             brp_pending
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_DIV);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] div_active;
    logic [WIDTH-1:0] div_shadow;
    logic             pending;
    logic             resync_i;
    logic             wrap;

`ifdef PRESCALE_RESYNC_EN
    always_comb resync_i = resync;
`else
    always_comb resync_i = 1'b0;
`endif

    always_comb wrap = (count == div_active);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (enable)  next_state = RUN;
            RUN:  if (!enable) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state and the pending flag
    always_comb begin
        busy        = (state == RUN);
        brp_pending = pending;
    end

    // Counter, strobe and divider registers
    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= '0;
            prescaler  <= 1'b0;
            div_active <= RESET_VAL;
            div_shadow <= RESET_VAL;
            pending    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    count     <= '0;
                    prescaler <= 1'b0;
                    // No period is running, so a load goes straight to use.
                    if (brp_load) begin
                        div_active <= brp;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        // Abort the partial period; a fresh load at this
                        // edge supersedes any value still in the shadow.
                        count     <= '0;
                        prescaler <= 1'b0;
                        pending   <= 1'b0;
                        if (brp_load) begin
                            div_active <= brp;
                        end else if (pending) begin
                            div_active <= div_shadow;
                        end
                    end else if (resync_i) begin
                        // Restart without a pulse; shadow stays pending.
                        count     <= '0;
                        prescaler <= 1'b0;
                        if (brp_load) begin
                            div_shadow <= brp;
                            pending    <= 1'b1;
                        end
                    end else if (wrap) begin
                        count     <= '0;
                        prescaler <= 1'b1;
                        pending   <= 1'b0;
                        if (brp_load) begin
                            div_active <= brp;
                        end else if (pending) begin
                            div_active <= div_shadow;
                        end
                    end else begin
                        count     <= count + 1'b1;
                        prescaler <= 1'b0;
                        if (brp_load) begin
                            div_shadow <= brp;
                            pending    <= 1'b1;
                        end
                    end
                end
                default: begin
                    count     <= '0;
                    prescaler <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prescale_gen.sv
// Directed testbench for prescale_gen (WIDTH = 6, RESET_DIV = 3).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.

module tb_prescale_gen;

    localparam int unsigned WIDTH = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] brp;
    logic             brp_load;
    logic             resync;
    logic             prescaler;
    logic             busy;
    logic             brp_pending;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    always #5 clock = ~clock;

    prescale_gen #(
        .WIDTH     (WIDTH),
        .RESET_DIV (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .brp         (brp),
        .brp_load    (brp_load),
`ifdef PRESCALE_RESYNC_EN
        .resync      (resync),
`endif
        .prescaler   (prescaler),
        .busy        (busy),
        .brp_pending (brp_pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance one edge per character of pat and compare prescaler to it.
    task automatic expect_pulses(input string tag, input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            tick();
            check($sformatf("%s[%0d]", tag, i + 1), {31'b0, prescaler},
                  (pat[i] == "1") ? 32'd1 : 32'd0);
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        brp      = v;
        brp_load = 1'b1;
        tick();
        brp_load = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        brp      = '0;
        brp_load = 1'b0;
        resync   = 1'b0;
        tick();
        tick();
        check("rst_prescaler", {31'b0, prescaler}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_pending", {31'b0, brp_pending}, 0);

        // Reset divider 3: period 4, first pulse at E4
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        check("div3_busy", {31'b0, busy}, 1);
        check("div3_e0", {31'b0, prescaler}, 0);
        expect_pulses("div3", "000100010001");
        check("div3_pending", {31'b0, brp_pending}, 0);

        // Divider 0: continuous strobe
        enable = 1'b0;
        tick();
        check("stop_busy", {31'b0, busy}, 0);
        check("stop_prescaler", {31'b0, prescaler}, 0);
        load(6'd0);
        enable = 1'b1;
        tick();
        check("div0_e0", {31'b0, prescaler}, 0);
        expect_pulses("div0", "11111");
        enable = 1'b0;
        tick();
        check("div0_off_busy", {31'b0, busy}, 0);
        check("div0_off_prescaler", {31'b0, prescaler}, 0);

        // Divider 5, load 1 at count 2
        enable = 1'b1;
        load(6'd5);               // E0, loaded in IDLE at the same edge
        expect_pulses("div5a", "00");
        load(6'd1);               // E3, count was 2
        check("reload_pending_e3", {31'b0, brp_pending}, 1);
        check("reload_e3", {31'b0, prescaler}, 0);
        expect_pulses("div5b", "00");
        check("reload_pending_e5", {31'b0, brp_pending}, 1);
        expect_pulses("div5c", "1");
        check("reload_pending_e6", {31'b0, brp_pending}, 0);
        expect_pulses("div1", "0101");
        expect_pulses("div1b", "0");
        load(6'd3);               // coincident with wrap at E12
        check("wrapload_e12", {31'b0, prescaler}, 1);
        check("wrapload_pending", {31'b0, brp_pending}, 0);
        expect_pulses("div3b", "0001");

        // Enable dropped at count 4 of divider 7 with pending load 2
        expect_pulses("pre7", "000");
        load(6'd7);               // wrap at E20
        check("load7_wrap", {31'b0, prescaler}, 1);
        expect_pulses("div7", "00");
        load(6'd2);               // E23, count 3
        check("abort_pending", {31'b0, brp_pending}, 1);
        expect_pulses("div7b", "0");
        enable = 1'b0;
        tick();                   // E25, count was 4
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_prescaler", {31'b0, prescaler}, 0);
        check("abort_pending_clr", {31'b0, brp_pending}, 0);
        enable = 1'b1;
        tick();
        check("div2_busy", {31'b0, busy}, 1);
        expect_pulses("div2", "001001");

        // Reset mid-period together with a load
        expect_pulses("prerst", "0");
        reset    = 1'b1;
        brp      = 6'd9;
        brp_load = 1'b1;
        tick();
        reset    = 1'b0;
        brp_load = 1'b0;
        check("mrst_prescaler", {31'b0, prescaler}, 0);
        check("mrst_busy", {31'b0, busy}, 0);
        check("mrst_pending", {31'b0, brp_pending}, 0);
        tick();                   // E0 after reset, enable still high
        check("mrst_e0_busy", {31'b0, busy}, 1);
        expect_pulses("mrst_div3", "00010001");

`ifdef PRESCALE_RESYNC_EN
        // Divider 4 with resync
        enable = 1'b0;
        tick();
        enable = 1'b1;
        load(6'd4);
        expect_pulses("rs_a", "00");
        resync = 1'b1;
        tick();                   // E3, count was 2
        resync = 1'b0;
        check("rs_mid", {31'b0, prescaler}, 0);
        expect_pulses("rs_b", "00001");
        expect_pulses("rs_c", "0000");
        resync = 1'b1;
        tick();                   // would wrap here
        resync = 1'b0;
        check("rs_wrap", {31'b0, prescaler}, 0);
        expect_pulses("rs_d", "00001");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
